// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a req/gnt +
// rvalid handshake, buffers returned words in an in-order queue and presents
// one instruction (with its PC) per cycle to the control stage. Redirects
// from the control stage flush the queue and drop any in-flight response.
module inst_fetch #(
    parameter int          N        = 32,
    parameter logic [N-1:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [N-1:0] NOP      = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         PCsel,
    input  logic [N-1:0] alu_target,
    input  logic         stall,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] inst,
    output logic [N-1:0] inst_pc,
    output logic         inst_valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   pc_reg, pc_next;
    logic [N-1:0]   out_addr_reg, out_addr_next;
    logic           outstanding_reg, outstanding_next;
    logic           discard_reg, discard_next;
    logic           redirect_reg, redirect_next;
    logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg;

    // Queue storage: data word and its fetch address, no reset needed.
    logic [N-1:0]   data_mem [DEPTH];
    logic [N-1:0]   addr_mem [DEPTH];

    logic fire;
    logic resp_ok;
    logic push;
    logic pop;

    // Handshake and queue control decode.
    always_comb begin
        // A request only goes out when nothing is in flight and the response
        // is guaranteed a slot; the cycle right after a redirect stays quiet.
        imem_req   = (state_reg == RUN) && !outstanding_reg && !redirect_reg
                     && (count_reg < DEPTH_C);
        imem_addr  = {pc_reg[N-1:2], 2'b00};
        fire       = imem_req && imem_gnt;
        resp_ok    = imem_rvalid && outstanding_reg;
        push       = resp_ok && !discard_reg && !PCsel;
        inst_valid = (count_reg != '0);
        pop        = inst_valid && !stall && !PCsel;
        inst       = inst_valid ? data_mem[rd_ptr_reg] : NOP;
        inst_pc    = inst_valid ? addr_mem[rd_ptr_reg] : '0;
    end

    // Next-state logic for PC, outstanding/discard tracking and the FSM.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        out_addr_next    = out_addr_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;
        redirect_next    = 1'b0;

        if (fire) begin
            outstanding_next = 1'b1;
            out_addr_next    = imem_addr;
            pc_next          = pc_reg + N'(4);
        end
        if (resp_ok) begin
            outstanding_next = 1'b0;
            discard_next     = 1'b0;
        end

        case (state_reg)
            BOOT:    state_next = RUN;
            DRAIN:   if (resp_ok) state_next = RUN;
            default: state_next = state_reg;
        endcase

        // A redirect wins over everything; whatever is still in flight after
        // this edge (old or just granted) must be thrown away on return.
        if (PCsel) begin
            pc_next       = {alu_target[N-1:2], 2'b00};
            redirect_next = 1'b1;
            discard_next  = outstanding_next;
            state_next    = outstanding_next ? DRAIN : RUN;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_PC;
            out_addr_reg    <= '0;
            outstanding_reg <= 1'b0;
            discard_reg     <= 1'b0;
            redirect_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            out_addr_reg    <= out_addr_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            redirect_reg    <= redirect_next;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (PCsel) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Queue entry write: returned word together with the address it came from.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem_rdata;
            addr_mem[wr_ptr_reg] <= out_addr_reg;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: boot/streaming, stall back-pressure,
// redirect with drop, grant stall, PC wrap and mid-fetch reset.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        PCsel;
    logic [31:0] alu_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;

    int total = 0;
    int bad   = 0;
    logic auto_resp;

    localparam logic [31:0] NOPW = 32'h0000_0013;

    inst_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .PCsel       (PCsel),
        .alu_target  (alu_target),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake mid-cycle, then (1-cycle memory)
    // return ~addr as the word one cycle after a granted request.
    task automatic tick();
        logic        hs;
        logic [31:0] ha;
        #4;
        hs = imem_req && imem_gnt;
        ha = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = hs && auto_resp;
        imem_rdata  = hs ? ~ha : 32'h0;
        $display("t=%0t req=%0b addr=%h gnt=%0b rvalid=%0b valid=%0b pc=%h inst=%h",
                 $time, imem_req, imem_addr, imem_gnt, imem_rvalid, inst_valid, inst_pc, inst);
    endtask

    initial begin
        rst = 1'b0; PCsel = 1'b0; alu_target = 32'h0; stall = 1'b0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0; auto_resp = 1'b1;

        @(posedge clk); #1;
        check("rst_inst", inst, NOPW);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        check("boot_req", 32'(imem_req), 32'h0);

        // Boot and stream with a 1-cycle memory.
        tick();
        check("first_req", 32'(imem_req), 32'h1);
        check("first_addr", imem_addr, 32'h0);
        tick();
        check("wait_valid", 32'(inst_valid), 32'h0);
        tick();
        check("v0_valid", 32'(inst_valid), 32'h1);
        check("v0_pc", inst_pc, 32'h0);
        check("v0_inst", inst, 32'hFFFF_FFFF);
        check("addr4", imem_addr, 32'h4);
        tick();
        tick();
        check("v1_pc", inst_pc, 32'h4);
        check("addr8", imem_addr, 32'h8);
        tick();
        tick();
        check("v2_pc", inst_pc, 32'h8);
        check("addrC", imem_addr, 32'hC);

        // Stall for 5 edges: queue fills, no request while full.
        stall = 1'b1;
        tick();
        tick();
        check("full_req", 32'(imem_req), 32'h0);
        check("full_pc", inst_pc, 32'h8);
        tick();
        check("full_req2", 32'(imem_req), 32'h0);
        tick();
        tick();
        check("hold_pc", inst_pc, 32'h8);
        check("hold_inst", inst, ~32'h8);
        stall = 1'b0;
        tick();
        check("rel_pc", inst_pc, 32'hC);
        check("rel_addr", imem_addr, 32'h10);
        check("rel_req", 32'(imem_req), 32'h1);
        tick();
        check("rel_empty", 32'(inst_valid), 32'h0);
        tick();
        check("v10_pc", inst_pc, 32'h10);
        check("addr14", imem_addr, 32'h14);

        // Redirect while a response is outstanding.
        auto_resp = 1'b0;
        tick();
        PCsel = 1'b1; alu_target = 32'h0000_0103;
        check("out_req", 32'(imem_req), 32'h0);
        tick();
        PCsel = 1'b0;
        check("rd_flush", 32'(inst_valid), 32'h0);
        check("rd_req", 32'(imem_req), 32'h0);
        imem_rvalid = 1'b1; imem_rdata = ~32'h14;
        auto_resp = 1'b1;
        tick();
        check("drop_valid", 32'(inst_valid), 32'h0);
        check("rd_req1", 32'(imem_req), 32'h1);
        check("rd_addr", imem_addr, 32'h100);
        tick();
        tick();
        check("rd_v_pc", inst_pc, 32'h100);
        check("rd_v_inst", inst, ~32'h100);
        check("addr104", imem_addr, 32'h104);

        // Grant held low for 3 cycles.
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ng_req", 32'(imem_req), 32'h1);
            check("ng_addr", imem_addr, 32'h104);
        end
        imem_gnt = 1'b1;
        tick();
        check("g_req", 32'(imem_req), 32'h0);
        tick();
        check("g_pc", inst_pc, 32'h104);
        check("g_addr", imem_addr, 32'h108);

        // Redirect with a same-cycle grant, then PC wrap.
        PCsel = 1'b1; alu_target = 32'hFFFF_FFFE;
        tick();
        PCsel = 1'b0;
        check("w_flush", 32'(inst_valid), 32'h0);
        check("w_req0", 32'(imem_req), 32'h0);
        tick();
        check("w_drop", 32'(inst_valid), 32'h0);
        check("w_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check("w_pc", inst_pc, 32'hFFFF_FFFC);
        check("w_inst", inst, 32'h0000_0003);
        check("wrap_addr", imem_addr, 32'h0);

        // Reset mid-fetch with a stray response after release.
        auto_resp = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("mr_inst", inst, NOPW);
        check("mr_valid", 32'(inst_valid), 32'h0);
        check("mr_req", 32'(imem_req), 32'h0);
        tick();
        rst = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        auto_resp = 1'b1;
        tick();
        check("st_valid", 32'(inst_valid), 32'h0);
        check("st_addr", imem_addr, 32'h0);
        check("st_req", 32'(imem_req), 32'h1);
        tick();
        tick();
        check("rs_pc", inst_pc, 32'h0);
        check("rs_inst", inst, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
